alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one combinational ALU (3-bit op code, W-bit A/B, result + Zero/Neg flags) between N requesters.
//  Round-robin grant, one operation in flight, valid/ready handshakes on both request and response sides.
//  Sits between issuing units (e.g. core pipe, address unit) and the single ALU instance; the ALU is external.
// PARAMETERS
//  W  32  operand/result width
//  N  4   number of requesters (2..8)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  reset        in   1     asynchronous, active-high reset
//  req_valid    in   N     requester i has an op pending
//  req_ready    out  N     one-hot accept; transfer when req_valid[i] & req_ready[i]
//  req_ctl      in   3*N   op code of requester i in bits [3i+2:3i]
//  req_a        in   W*N   operand A of requester i in bits [Wi+W-1:Wi]
//  req_b        in   W*N   operand B of requester i, same packing as req_a
//  rsp_valid    out  N     one-hot: result belongs to requester i
//  rsp_ready    in   N     requester i takes the response
//  rsp_result   out  W     registered ALU result
//  rsp_zero     out  1     registered Zero flag
//  rsp_neg      out  1     registered Neg flag
//  alu_ctl      out  3     to ALU op select
//  alu_a        out  W     to ALU A
//  alu_b        out  W     to ALU B
//  alu_out      in   W     from ALU result
//  alu_zero     in   1     from ALU Zero
//  alu_neg      in   1     from ALU Neg
// BEHAVIOUR
//  - Reset: state=IDLE, ptr=0, owner=0, op/operand regs=0, result/flags=0; req_ready=0, rsp_valid=0.
//  - IDLE: req_ready[win]=1 combinationally iff any req_valid. win = first i with req_valid[i],
//    searching ptr, ptr+1, ..., wrapping mod N. On the edge: latch ctl/a/b, owner<=win,
//    ptr<=(win+1) mod N (wrap N-1 -> 0), go EXEC.
//  - EXEC: req_ready=0. alu_* driven from the latched regs (always, in every state). On the edge:
//    capture alu_out/alu_zero/alu_neg into rsp_* regs, go RESP.
//  - RESP: rsp_valid[owner]=1, all other bits 0. Hold while rsp_ready[owner]=0; result and flags
//    stay stable. On rsp_ready[owner], go IDLE; rsp_ready of other requesters is ignored.
//  - Latency: accept at edge t, result captured at t+1, rsp_valid high from cycle after t+1.
//    Minimum 3 cycles per op (no overlap of RESP and accept).
//  - Op codes are passed through unchanged: 0 add, 1 and, 2 or, 3 sll, 4 sra, 5 srl, 6 sub, 7 xor.
//    No width extension; shift amounts are the ALU's concern.
//  - Requesters need not hold req_valid stable before grant. A withdrawn request is simply not
//    considered. No grant occurs with no valid.
//  - Only one ready bit is high in any cycle; only one rsp_valid bit is high in any cycle.
//  - Reset asserted mid-EXEC/RESP: in-flight op and response are discarded, and all regs go to reset values.
// STRUCTURE
//  - Shared package alu_pkg:
//    - localparams ALU_ADD=0, ALU_AND=1, ALU_OR=2, ALU_SLL=3, ALU_SRA=4, ALU_SRL=5, ALU_SUB=6, ALU_XOR=7
//    - state encoding ST_IDLE, ST_EXEC, ST_RESP (2 bits)
//  - Sub-module rr_pick #(N): combinational; inputs req[N], ptr; outputs any, win index.
//  - Top holds the FSM, ptr, and the operand/result registers.
// TESTING
//  1. Single req: req0 valid, ctl=0, a=5, b=7 -> req_ready=0001 same cycle; rsp_valid=0001,
//     rsp_result=12, zero=0, neg=0, two edges later.
//  2. Flags: ctl=6, a=3, b=3 -> result=0, zero=1; ctl=6, a=3, b=5 -> result=0xFFFFFFFE, neg=1.
//  3. Fairness: all 4 valid continuously from reset -> grants 0,1,2,3,0; each appears once per 4 ops.
//  4. Wrap/skip: ptr=3 (after granting 2), only req1 valid -> grant 1, ptr becomes 2.
//  5. Backpressure: rsp_ready low 5 cycles in RESP -> rsp_* stable, req_ready stays 0;
//     req2's valid waits; grant to req2 the cycle after rsp_ready.
//  6. Reset in RESP -> rsp_valid=0, state IDLE, ptr=0 immediately; next grant with all valid is req0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU round-robin arbiter: ALU op codes,
// arbiter state encoding and the round-robin successor helper.
package alu_pkg;

    // Op codes forwarded unchanged to the external ALU.
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_AND = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_SLL = 3'd3;
    localparam logic [2:0] ALU_SRA = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    localparam int CTL_W = 3;

    // One op in flight: accept (IDLE), ALU evaluates (EXEC), result offered (RESP).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Index following idx in a ring of n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Bus bundle between N requesters, the arbiter and the external ALU.
// slave  : arbiter view.
// master : requesters plus ALU view (the environment around the arbiter).
interface alu_rr_arbiter_if #(
    parameter int W = 32,
    parameter int N = 4
);
    // Request side
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_ctl;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;

    // Response side
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           rsp_zero;
    logic           rsp_neg;

    // External ALU
    logic [2:0]     alu_ctl;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_out;
    logic           alu_zero;
    logic           alu_neg;

    modport slave (
        input  req_valid, req_ctl, req_a, req_b,
        output req_ready,
        output rsp_valid, rsp_result, rsp_zero, rsp_neg,
        input  rsp_ready,
        output alu_ctl, alu_a, alu_b,
        input  alu_out, alu_zero, alu_neg
    );

    modport master (
        output req_valid, req_ctl, req_a, req_b,
        input  req_ready,
        input  rsp_valid, rsp_result, rsp_zero, rsp_neg,
        output rsp_ready,
        input  alu_ctl, alu_a, alu_b,
        output alu_out, alu_zero, alu_neg
    );

endinterface

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] win
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        logic [PW-1:0] idx;
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        any = 1'b0;
        win = '0;
        idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between N
// requesters. One op in flight: accept, execute, respond (3 cycles minimum).
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              reset,
    alu_rr_arbiter_if.slave   bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [2:0]      ctl_q, ctl_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic            zero_q, zero_d;
    logic            neg_q, neg_d;

    logic            pick_any;
    logic [PW-1:0]   pick_win;
    logic [N-1:0]    req_ready_c;
    logic [N-1:0]    rsp_valid_c;

    rr_pick #(.N(N)) u_pick (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .win (pick_win)
    );

    // Next-state, grant, operand latch and result capture.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        ctl_d       = ctl_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        req_ready_c = '0;
        rsp_valid_c = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Ready is held low while reset is asserted even though the
                // state register already reads IDLE.
                if (pick_any && !reset) begin
                    for (int i = 0; i < N; i++) begin
                        if (PW'(i) == pick_win) begin
                            req_ready_c[i] = 1'b1;
                            ctl_d          = bus.req_ctl[CTL_W*i +: CTL_W];
                            a_d            = bus.req_a[W*i +: W];
                            b_d            = bus.req_b[W*i +: W];
                        end
                    end
                    owner_d = pick_win;
                    ptr_d   = PW'(rr_next(int'(pick_win), N));
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                result_d = bus.alu_out;
                zero_d   = bus.alu_zero;
                neg_d    = bus.alu_neg;
                state_d  = ST_RESP;
            end

            ST_RESP: begin
                // Only the owner's rsp_ready releases the response.
                for (int i = 0; i < N; i++) begin
                    if (PW'(i) == owner_q) begin
                        rsp_valid_c[i] = 1'b1;
                        if (bus.rsp_ready[i]) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointer, operand and result registers; reset discards any in-flight op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            ctl_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            ctl_q    <= ctl_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = rsp_valid_c;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_neg    = neg_q;
    assign bus.alu_ctl    = ctl_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_alu_rr_arbiter;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int N = 4;

    logic clk;
    logic reset;

    alu_rr_arbiter_if #(.W(W), .N(N)) bus ();

    alu_rr_arbiter #(.W(W), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural external ALU.
    function automatic logic [W-1:0] alu_fn(input logic [2:0] c, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (c)
            ALU_ADD: return a + b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLL: return a << b[4:0];
            ALU_SRA: return W'($signed(a) >>> b[4:0]);
            ALU_SRL: return a >> b[4:0];
            ALU_SUB: return a - b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb begin
        bus.alu_out  = alu_fn(bus.alu_ctl, bus.alu_a, bus.alu_b);
        bus.alu_zero = (bus.alu_out == '0);
        bus.alu_neg  = bus.alu_out[W-1];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: transaction view (is an op outstanding, how long since
    // accept, who owns it, what it must return) plus the round-robin pointer.
    int             m_ptr   = 0;
    bit             m_busy  = 0;
    int             m_age   = 0;
    int             m_owner = 0;
    logic [W-1:0]   m_res   = '0;
    logic [2:0]     m_ctl   = '0;
    logic [W-1:0]   m_a     = '0;
    logic [W-1:0]   m_b     = '0;

    // Observations used by the directed scenarios.
    int             last_grant  = -1;
    logic [W-1:0]   last_result = '0;
    logic           last_zero   = 1'b0;
    logic           last_neg    = 1'b0;
    int             rsp_done    = 0;
    bit             ready_seen  = 0;

    function automatic int pick(input int p, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Check one cycle's outputs against the model, then advance one edge.
    // Called at posedge+1 with inputs already set for the cycle.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_rv;
        int           g;
        logic [2:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        #1;
        exp_ready = '0;
        exp_rv    = '0;
        g         = -1;
        c         = '0;
        a         = '0;
        b         = '0;
        if (!reset) begin
            if (!m_busy) begin
                g = pick(m_ptr, bus.req_valid);
                if (g >= 0) begin
                    exp_ready[g] = 1'b1;
                    c = bus.req_ctl[3*g +: 3];
                    a = bus.req_a[W*g +: W];
                    b = bus.req_b[W*g +: W];
                end
            end else if (m_age >= 1) begin
                exp_rv[m_owner] = 1'b1;
            end
        end
        check("req_ready", bus.req_ready, exp_ready);
        check("rsp_valid", bus.rsp_valid, exp_rv);
        if (!reset && m_busy) begin
            check("alu_ctl", bus.alu_ctl, m_ctl);
            check("alu_a", bus.alu_a, m_a);
            check("alu_b", bus.alu_b, m_b);
            if (m_age >= 1) begin
                check("rsp_result", bus.rsp_result, m_res);
                check("rsp_zero", bus.rsp_zero, m_res == '0);
                check("rsp_neg", bus.rsp_neg, m_res[W-1]);
            end
        end
        if (bus.req_ready != '0) begin
            last_grant = onehot_idx(bus.req_ready);
            ready_seen = 1;
        end
        if (|(bus.rsp_valid & bus.rsp_ready)) begin
            last_result = bus.rsp_result;
            last_zero   = bus.rsp_zero;
            last_neg    = bus.rsp_neg;
            rsp_done++;
        end
        @(posedge clk);
        if (reset) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            if (g >= 0) begin
                m_busy  = 1;
                m_age   = 0;
                m_owner = g;
                m_ptr   = (g + 1) % N;
                m_ctl   = c;
                m_a     = a;
                m_b     = b;
                m_res   = alu_fn(c, a, b);
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (bus.rsp_ready[m_owner]) begin
            m_busy = 0;
        end
        #1;
    endtask

    task automatic set_op(input int i, input logic [2:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        bus.req_ctl[3*i +: 3] = c;
        bus.req_a[W*i +: W]   = a;
        bus.req_b[W*i +: W]   = b;
    endtask

    // Run cycles until one more response handshake completes.
    task automatic wait_rsp(input int budget);
        int start;
        start = rsp_done;
        for (int k = 0; k < budget && rsp_done == start; k++) cycle();
        if (rsp_done == start) check("rsp_timeout", 0, 1);
    endtask

    // Wait (bounded) until a response is being offered.
    task automatic wait_rsp_valid(input int budget);
        for (int k = 0; k < budget && bus.rsp_valid == '0; k++) cycle();
        if (bus.rsp_valid == '0) check("rsp_valid_timeout", 0, 1);
    endtask

    // Reset pulse of one clock edge; called at posedge+1.
    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        #1;
        check("rst_rsp_valid", bus.rsp_valid, '0);
        check("rst_req_ready", bus.req_ready, '0);
        check("rst_rsp_result", bus.rsp_result, '0);
        m_busy = 0;
        m_ptr  = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_ctl   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;

        // Reset state, with requests present to confirm no grant under reset.
        @(posedge clk);
        #1;
        bus.req_valid = '1;
        @(posedge clk);
        #1;
        check("reset_req_ready", bus.req_ready, '0);
        check("reset_rsp_valid", bus.rsp_valid, '0);
        check("reset_rsp_result", bus.rsp_result, '0);
        check("reset_flags", {bus.rsp_zero, bus.rsp_neg}, 2'b00);
        check("reset_alu_ctl", bus.alu_ctl, '0);
        check("reset_alu_ab", {bus.alu_a, bus.alu_b}, '0);
        bus.req_valid = '0;
        reset         = 1'b0;

        // 1. Single request: 5 + 7.
        set_op(0, ALU_ADD, 32'd5, 32'd7);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = '1;
        wait_rsp(10);
        bus.req_valid = '0;
        check("t1_grant", last_grant, 0);
        check("t1_result", last_result, 12);
        check("t1_flags", {last_zero, last_neg}, 2'b00);

        // 2. Flags from subtraction.
        set_op(0, ALU_SUB, 32'd3, 32'd3);
        bus.req_valid = 4'b0001;
        wait_rsp(10);
        bus.req_valid = '0;
        check("t2_zero_result", last_result, 0);
        check("t2_zero_flag", last_zero, 1);
        set_op(0, ALU_SUB, 32'd3, 32'd5);
        bus.req_valid = 4'b0001;
        wait_rsp(10);
        bus.req_valid = '0;
        check("t2_neg_result", last_result, 32'hFFFF_FFFE);
        check("t2_neg_flag", last_neg, 1);
        check("t2_neg_zero", last_zero, 0);

        // 3. Fairness: all requesters valid continuously from reset.
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 3'($urandom), W'($urandom), W'($urandom));
        bus.req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(10);
            check($sformatf("t3_grant%0d", k), last_grant, k % N);
        end

        // 4. Wrap and skip: grant 2 (ptr -> 3), then only req1 -> grant 1 (ptr -> 2).
        bus.req_valid = 4'b0100;
        wait_rsp(10);
        check("t4_grant2", last_grant, 2);
        bus.req_valid = 4'b0010;
        wait_rsp(10);
        check("t4_grant1", last_grant, 1);
        bus.req_valid = '1;
        wait_rsp(10);
        check("t4_ptr_after_wrap", last_grant, 2);
        bus.req_valid = '0;

        // 5. Backpressure in RESP; req2 waits, other rsp_ready bits ignored.
        do_reset();
        set_op(0, ALU_XOR, 32'hA5A5_0000, 32'h0000_5A5A);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = '0;
        wait_rsp_valid(10);
        bus.req_valid = 4'b0100;
        set_op(2, ALU_OR, 32'h0F, 32'hF0);
        bus.rsp_ready = 4'b1110;
        ready_seen    = 0;
        repeat (5) cycle();
        check("t5_ready_held", ready_seen, 0);
        check("t5_rsp_held", bus.rsp_valid, 4'b0001);
        bus.rsp_ready = 4'b0001;
        cycle();
        check("t5_result", last_result, 32'hA5A5_5A5A);
        cycle();
        check("t5_grant_req2", last_grant, 2);
        bus.rsp_ready = '1;
        wait_rsp(10);
        bus.req_valid = '0;
        check("t5_req2_result", last_result, 32'hFF);

        // 6. Reset while a response is held.
        do_reset();
        set_op(0, ALU_ADD, 32'd100, 32'd23);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = '0;
        wait_rsp_valid(10);
        do_reset();
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        wait_rsp(10);
        check("t6_grant_after_reset", last_grant, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(149) == 0) begin
                reset         = 1'b1;
                bus.req_valid = N'($urandom);
                cycle();
                reset = 1'b0;
            end else begin
                bus.req_valid = N'($urandom);
                for (int i = 0; i < N; i++)
                    set_op(i, 3'($urandom), rand_operand(), rand_operand());
                bus.rsp_ready = ($urandom_range(3) != 0) ? N'('1) : N'($urandom);
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
